// File: rtl/b2_scfifo_pkg.sv
// b2_scfifo_pkg: shared constants and helpers for the b2_scfifo single-clock FIFO.
//   SHOWAHEAD_ON / SHOWAHEAD_OFF : legal values of the SHOWAHEAD parameter
//   usedw_width()                : width of the stored-word count for a given address width
package b2_scfifo_pkg;

    localparam string SHOWAHEAD_ON  = "ON";
    localparam string SHOWAHEAD_OFF = "OFF";

    // Count must represent 0..2**awidth inclusive, hence one extra bit.
    function automatic int unsigned usedw_width(input int unsigned awidth);
        return awidth + 1;
    endfunction

endpackage

// File: rtl/b2_scfifo_mem.sv
// b2_scfifo_mem: simple dual-port storage, DWIDTH x 2**AWIDTH, no reset.
//   clk     : clock
//   wr_en   : write strobe, wr_addr/wr_data : write port
//   rd_en   : read strobe, rd_addr : read address
//   rd_data : registered read data (old contents on a same-address write)
module b2_scfifo_mem #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/b2_scfifo.sv
// b2_scfifo: single-clock FIFO with show-ahead or normal read mode.
//   clk_i, srst_i (sync, active-high)
//   wrreq_i, data_i : write side        rdreq_i : read request / show-ahead acknowledge
//   q_o             : read data          usedw_o : stored-word count 0..2**AWIDTH
//   empty_o, full_o, almost_empty_o, almost_full_o : status flags
//   ovf_o, udf_o    : sticky error flags, present only with B2_SCFIFO_ERR_FLAGS_EN defined
//                     (tied to 0 otherwise)
module b2_scfifo
    import b2_scfifo_pkg::*;
#(
    parameter int unsigned DWIDTH             = 8,
    parameter int unsigned AWIDTH             = 8,
    parameter string       SHOWAHEAD          = "ON",
    parameter int unsigned ALMOST_FULL_VALUE  = 2 ** AWIDTH - 1,
    parameter int unsigned ALMOST_EMPTY_VALUE = 1
) (
    input  logic                             clk_i,
    input  logic                             srst_i,
    input  logic                             wrreq_i,
    input  logic [DWIDTH-1:0]                data_i,
    input  logic                             rdreq_i,
    output logic [DWIDTH-1:0]                q_o,
    output logic [usedw_width(AWIDTH)-1:0]   usedw_o,
    output logic                             empty_o,
    output logic                             full_o,
    output logic                             almost_empty_o,
    output logic                             almost_full_o,
    output logic                             ovf_o,
    output logic                             udf_o
);

    localparam int unsigned UW    = usedw_width(AWIDTH);
    localparam int unsigned DEPTH = 2 ** AWIDTH;
    localparam bit          SA    = (SHOWAHEAD == SHOWAHEAD_ON);

    // Elaboration-time parameter checks.
    if (!((SHOWAHEAD == SHOWAHEAD_ON) || (SHOWAHEAD == SHOWAHEAD_OFF))) begin : g_bad_mode
        $error("b2_scfifo: SHOWAHEAD must be \"ON\" or \"OFF\"");
    end
    if (!((ALMOST_EMPTY_VALUE >= 1) && (ALMOST_EMPTY_VALUE <= ALMOST_FULL_VALUE) &&
          (ALMOST_FULL_VALUE <= DEPTH))) begin : g_bad_thresh
        $error("b2_scfifo: need 1 <= ALMOST_EMPTY_VALUE <= ALMOST_FULL_VALUE <= 2**AWIDTH");
    end

    logic [AWIDTH-1:0] wr_ptr, rd_ptr, rd_ptr_inc, rd_addr;
    logic [UW-1:0]     usedw_q, usedw_next;
    logic              empty_q, full_q, ae_q, af_q;
    logic              wr_acc, rd_acc;
    logic              mem_rd_en, byp_load;
    logic              q_sel;
    logic [DWIDTH-1:0] q_byp, mem_q;

    // Accepted accesses; requests in a reset cycle are ignored.
    always_comb begin
        wr_acc     = wrreq_i & ~full_q & ~srst_i;
        rd_acc     = rdreq_i & ~empty_q & ~srst_i;
        rd_ptr_inc = rd_ptr + AWIDTH'(1);
    end

    // Next count and read-data sourcing.
    always_comb begin
        usedw_next = usedw_q;
        rd_addr    = rd_ptr;
        mem_rd_en  = rd_acc;
        byp_load   = 1'b0;
        case ({wr_acc, rd_acc})
            2'b10:   usedw_next = usedw_q + UW'(1);
            2'b01:   usedw_next = usedw_q - UW'(1);
            default: usedw_next = usedw_q;
        endcase
        if (SA) begin
            // Prefetch the word that becomes oldest after this edge. If that word is
            // the one being written now, the RAM still holds stale data at that
            // address, so capture it straight from data_i instead.
            rd_addr   = rd_acc ? rd_ptr_inc : rd_ptr;
            mem_rd_en = rd_acc && (usedw_q > UW'(1));
            byp_load  = wr_acc && (usedw_q == UW'(rd_acc));
        end
    end

    // Pointers, count, flags and read-data select.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            usedw_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= 1'b0;
            q_sel   <= 1'b1;
            q_byp   <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AWIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr_inc;
            end
            usedw_q <= usedw_next;
            empty_q <= (usedw_next == '0);
            full_q  <= (usedw_next == UW'(DEPTH));
            ae_q    <= (usedw_next <  UW'(ALMOST_EMPTY_VALUE));
            af_q    <= (usedw_next >= UW'(ALMOST_FULL_VALUE));
            if (byp_load) begin
                q_sel <= 1'b1;
                q_byp <= data_i;
            end else if (mem_rd_en) begin
                q_sel <= 1'b0;
            end
        end
    end

    b2_scfifo_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk     (clk_i),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_i),
        .rd_en   (mem_rd_en),
        .rd_addr (rd_addr),
        .rd_data (mem_q)
    );

    // Both sources are registers; the select is reset so q_o reads 0 after reset.
    assign q_o            = q_sel ? q_byp : mem_q;
    assign usedw_o        = usedw_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign almost_empty_o = ae_q;
    assign almost_full_o  = af_q;

`ifdef B2_SCFIFO_ERR_FLAGS_EN
    logic ovf_q, udf_q;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wrreq_i && full_q) begin
                ovf_q <= 1'b1;
            end
            if (rdreq_i && empty_q) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
`else
    assign ovf_o = 1'b0;
    assign udf_o = 1'b0;
`endif

endmodule

// File: tb/tb_b2_scfifo.sv
// tb_b2_scfifo: bench for b2_scfifo, one show-ahead and one normal-mode instance
// driven by identical stimulus (DWIDTH=8, AWIDTH=3, thresholds 6/2).
module tb_b2_scfifo;

    logic       clk = 1'b0;
    logic       srst = 1'b0, wrreq = 1'b0, rdreq = 1'b0;
    logic [7:0] data = 8'h00;

    logic [7:0] q_sa, q_off;
    logic [3:0] uw_sa, uw_off;
    logic       e_sa, f_sa, ae_sa, af_sa, ov_sa, ud_sa;
    logic       e_off, f_off, ae_off, af_off, ov_off, ud_off;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_q;

`ifdef B2_SCFIFO_ERR_FLAGS_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    b2_scfifo #(.DWIDTH(8), .AWIDTH(3), .SHOWAHEAD("ON"),
                .ALMOST_FULL_VALUE(6), .ALMOST_EMPTY_VALUE(2)) u_sa (
        .clk_i(clk), .srst_i(srst), .wrreq_i(wrreq), .data_i(data), .rdreq_i(rdreq),
        .q_o(q_sa), .usedw_o(uw_sa), .empty_o(e_sa), .full_o(f_sa),
        .almost_empty_o(ae_sa), .almost_full_o(af_sa), .ovf_o(ov_sa), .udf_o(ud_sa));

    b2_scfifo #(.DWIDTH(8), .AWIDTH(3), .SHOWAHEAD("OFF"),
                .ALMOST_FULL_VALUE(6), .ALMOST_EMPTY_VALUE(2)) u_off (
        .clk_i(clk), .srst_i(srst), .wrreq_i(wrreq), .data_i(data), .rdreq_i(rdreq),
        .q_o(q_off), .usedw_o(uw_off), .empty_o(e_off), .full_o(f_off),
        .almost_empty_o(ae_off), .almost_full_o(af_off), .ovf_o(ov_off), .udf_o(ud_off));

    wire [7:0] st_sa  = {uw_sa, e_sa, f_sa, ae_sa, af_sa};
    wire [7:0] st_off = {uw_off, e_off, f_off, ae_off, af_off};

    // Expected {usedw, empty, full, almost_empty, almost_full} for a count of n.
    function automatic logic [7:0] exp_stat(input int n);
        return {4'(n), (n == 0), (n == 8), (n < 2), (n >= 6)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        srst = 1'b1; wrreq = 1'b1; rdreq = 1'b1; data = 8'h55;
        cyc();
        srst = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
        sb.delete();
        checks++;
        if ({st_sa, st_off} !== {2{exp_stat(0)}}) begin
            failures++;
            $display("FAIL reset_status: got %h/%h expected %h", st_sa, st_off, exp_stat(0));
        end
        checks++;
        if ({q_sa, q_off, ov_sa, ud_sa, ov_off, ud_off} !== 20'h0) begin
            failures++;
            $display("FAIL reset_q_err: got q %h/%h err %b%b%b%b expected zeros",
                     q_sa, q_off, ov_sa, ud_sa, ov_off, ud_off);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            wrreq = 1'b1; data = 8'(i);
            sb.push_back(8'(i));
            cyc();
            checks++;
            if ({st_sa, st_off} !== {2{exp_stat(i)}}) begin
                failures++;
                $display("FAIL fill_status[%0d]: got %h/%h expected %h", i, st_sa, st_off, exp_stat(i));
            end
            checks++;
            if (q_sa !== 8'h01) begin
                failures++;
                $display("FAIL fill_q_sa[%0d]: got %h expected 01", i, q_sa);
            end
        end
        data = 8'hFF;
        cyc();
        wrreq = 1'b0;
        checks++;
        if ({st_sa, st_off} !== {2{exp_stat(8)}}) begin
            failures++;
            $display("FAIL overflow_status: got %h/%h expected %h", st_sa, st_off, exp_stat(8));
        end
        checks++;
        if ({ov_sa, ud_sa, ov_off, ud_off} !== {ERR, 1'b0, ERR, 1'b0}) begin
            failures++;
            $display("FAIL overflow_flags: got %b%b%b%b expected %b0%b0",
                     ov_sa, ud_sa, ov_off, ud_off, ERR, ERR);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_sa !== sb[0]) begin
                failures++;
                $display("FAIL drain_q_sa[%0d]: got %h expected %h", i, q_sa, sb[0]);
            end
            exp_q = sb.pop_front();
            rdreq = 1'b1;
            cyc();
            rdreq = 1'b0;
            checks++;
            if (q_off !== exp_q) begin
                failures++;
                $display("FAIL drain_q_off[%0d]: got %h expected %h", i, q_off, exp_q);
            end
            checks++;
            if ({st_sa, st_off} !== {2{exp_stat(7 - i)}}) begin
                failures++;
                $display("FAIL drain_status[%0d]: got %h/%h expected %h", i, st_sa, st_off, exp_stat(7 - i));
            end
        end
        rdreq = 1'b1;
        cyc();
        rdreq = 1'b0;
        checks++;
        if ({q_off, st_sa, st_off} !== {8'h08, exp_stat(0), exp_stat(0)}) begin
            failures++;
            $display("FAIL underflow_q_status: got q %h st %h/%h expected q 08 st %h",
                     q_off, st_sa, st_off, exp_stat(0));
        end
        checks++;
        if ({ov_sa, ud_sa, ov_off, ud_off} !== {4{ERR}}) begin
            failures++;
            $display("FAIL underflow_flags: got %b%b%b%b expected %b%b%b%b",
                     ov_sa, ud_sa, ov_off, ud_off, ERR, ERR, ERR, ERR);
        end
    endtask

    task automatic test_showahead_single();
        srst = 1'b1;
        cyc();
        srst = 1'b0;
        sb.delete();
        wrreq = 1'b1; data = 8'hA5;
        sb.push_back(8'hA5);
        cyc();
        wrreq = 1'b0;
        checks++;
        if ({q_sa, st_sa} !== {8'hA5, exp_stat(1)}) begin
            failures++;
            $display("FAIL sa_single: got q %h st %h expected q a5 st %h", q_sa, st_sa, exp_stat(1));
        end
        exp_q = sb.pop_front();
        rdreq = 1'b1;
        cyc();
        rdreq = 1'b0;
        checks++;
        if ({q_off, st_off} !== {exp_q, exp_stat(0)}) begin
            failures++;
            $display("FAIL sa_single_off: got q %h st %h expected q %h st %h", q_off, st_off, exp_q, exp_stat(0));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            wrreq = 1'b1; data = d;
            sb.push_back(d);
            cyc();
        end
        wrreq = 1'b0;
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            checks++;
            if (q_sa !== sb[0]) begin
                failures++;
                $display("FAIL b2b_q_sa[%0d]: got %h expected %h", i, q_sa, sb[0]);
            end
            exp_q = sb.pop_front();
            sb.push_back(d);
            wrreq = 1'b1; rdreq = 1'b1; data = d;
            cyc();
            checks++;
            if ({q_off, st_sa, st_off} !== {exp_q, exp_stat(4), exp_stat(4)}) begin
                failures++;
                $display("FAIL b2b_off[%0d]: got q %h st %h/%h expected q %h st %h",
                         i, q_off, st_sa, st_off, exp_q, exp_stat(4));
            end
        end
        wrreq = 1'b0; rdreq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_sa !== sb[0]) begin
                failures++;
                $display("FAIL b2b_drain_q_sa[%0d]: got %h expected %h", i, q_sa, sb[0]);
            end
            exp_q = sb.pop_front();
            rdreq = 1'b1;
            cyc();
            rdreq = 1'b0;
            checks++;
            if ({q_off, st_off} !== {exp_q, exp_stat(3 - i)}) begin
                failures++;
                $display("FAIL b2b_drain_off[%0d]: got q %h st %h expected q %h st %h",
                         i, q_off, st_off, exp_q, exp_stat(3 - i));
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            wrreq = 1'b1; data = 8'(8'h10 + i);
            sb.push_back(8'(8'h10 + i));
            cyc();
        end
        checks++;
        if ({st_sa, st_off} !== {2{exp_stat(5)}}) begin
            failures++;
            $display("FAIL pre_reset_status: got %h/%h expected %h", st_sa, st_off, exp_stat(5));
        end
        srst = 1'b1; wrreq = 1'b1; data = 8'h77;
        cyc();
        srst = 1'b0; wrreq = 1'b0;
        sb.delete();
        checks++;
        if ({q_sa, q_off, st_sa, st_off, ov_sa, ud_sa, ov_off, ud_off} !==
            {16'h0, exp_stat(0), exp_stat(0), 4'b0}) begin
            failures++;
            $display("FAIL mid_reset: got q %h/%h st %h/%h err %b%b%b%b expected q 00 st %h err 0000",
                     q_sa, q_off, st_sa, st_off, ov_sa, ud_sa, ov_off, ud_off, exp_stat(0));
        end
        wrreq = 1'b1; data = 8'h3C;
        sb.push_back(8'h3C);
        cyc();
        wrreq = 1'b0;
        checks++;
        if ({q_sa, st_sa} !== {sb[0], exp_stat(1)}) begin
            failures++;
            $display("FAIL post_reset_sa: got q %h st %h expected q %h st %h", q_sa, st_sa, sb[0], exp_stat(1));
        end
        exp_q = sb.pop_front();
        rdreq = 1'b1;
        cyc();
        rdreq = 1'b0;
        checks++;
        if ({q_off, st_sa, st_off} !== {exp_q, exp_stat(0), exp_stat(0)}) begin
            failures++;
            $display("FAIL post_reset_off: got q %h st %h/%h expected q %h st %h",
                     q_off, st_sa, st_off, exp_q, exp_stat(0));
        end
    endtask

    initial begin
        cyc();
        test_reset();
        test_fill();
        test_drain();
        test_showahead_single();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
